// File: rtl/ball_motion.sv
// Ball position/direction tracker with a tick divider and a serve/move/lost FSM.
// Walls bounce the ball; reaching the floor reports a miss and waits for a re-serve.
module ball_motion #(
  parameter int W      = 10,
  parameter int SW     = 3,
  parameter int DIV    = 1,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 631,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 471,
  parameter int X_INIT = 316,
  parameter int Y_INIT = 400
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_launch,
  input  logic [SW-1:0] i_step_x,
  input  logic [SW-1:0] i_step_y,
  input  logic          i_flip_x,
  input  logic          i_flip_y,
  output logic [W-1:0]  o_x,
  output logic [W-1:0]  o_y,
  output logic          o_x_du,
  output logic          o_y_du,
  output logic          o_wall_hit,
  output logic          o_miss,
  output logic          o_moving
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [W:0] XMIN_E = (W+1)'(X_MIN);
  localparam logic [W:0] XMAX_E = (W+1)'(X_MAX);
  localparam logic [W:0] YMIN_E = (W+1)'(Y_MIN);
  localparam logic [W:0] YMAX_E = (W+1)'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_LOST} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_x, r_y, w_x_nxt, w_y_nxt;
  logic           r_x_du, r_y_du, w_x_du_nxt, w_y_du_nxt;
  logic           r_wall, r_miss, w_wall_nxt, w_miss_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;

  // All position math is one bit wider so overflow/underflow are visible
  logic [W:0] w_sx, w_sy, w_xe, w_ye;
  logic [W:0] w_x_inc, w_x_dec, w_y_inc, w_y_dec;
  logic       w_xd, w_yd, w_tick;
  logic       w_x_hi, w_x_lo, w_y_top, w_y_floor;

  assign w_sx    = (W+1)'(i_step_x);
  assign w_sy    = (W+1)'(i_step_y);
  assign w_xe    = {1'b0, r_x};
  assign w_ye    = {1'b0, r_y};
  assign w_x_inc = w_xe + w_sx;
  assign w_x_dec = w_xe - w_sx;
  assign w_y_inc = w_ye + w_sy;
  assign w_y_dec = w_ye - w_sy;
  assign w_xd    = r_x_du ^ i_flip_x;
  assign w_yd    = r_y_du ^ i_flip_y;
  assign w_tick  = i_enable && (r_cnt == CNT_LAST);

  // Comparing against MIN+step avoids relying on the wrapped difference
  assign w_x_hi    =  w_xd && (w_x_inc > XMAX_E);
  assign w_x_lo    = !w_xd && (w_xe < XMIN_E + w_sx);
  assign w_y_floor =  w_yd && (w_y_inc >= YMAX_E);
  assign w_y_top   = !w_yd && (w_ye < YMIN_E + w_sy);

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_x_du_nxt  = r_x_du;
    w_y_du_nxt  = r_y_du;
    w_cnt_nxt   = r_cnt;
    w_wall_nxt  = 1'b0;
    w_miss_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_launch) w_state_nxt = S_MOVE;
      end
      S_LOST: begin
        w_cnt_nxt = '0;
        if (i_launch) begin
          w_x_nxt     = W'(X_INIT);
          w_y_nxt     = W'(Y_INIT);
          w_x_du_nxt  = 1'b1;
          w_y_du_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_MOVE: begin
        w_x_du_nxt = w_xd;
        w_y_du_nxt = w_yd;
        if (i_enable) w_cnt_nxt = w_tick ? '0 : CW'(r_cnt + 1'b1);
        if (w_tick) begin
          if (w_x_hi) begin
            w_x_nxt    = W'(X_MAX);
            w_x_du_nxt = 1'b0;
          end else if (w_x_lo) begin
            w_x_nxt    = W'(X_MIN);
            w_x_du_nxt = 1'b1;
          end else begin
            w_x_nxt = w_xd ? w_x_inc[W-1:0] : w_x_dec[W-1:0];
          end
          if (w_y_floor) begin
            w_y_nxt     = W'(Y_MAX);
            w_miss_nxt  = 1'b1;
            w_state_nxt = S_LOST;
          end else if (w_y_top) begin
            w_y_nxt    = W'(Y_MIN);
            w_y_du_nxt = 1'b1;
          end else begin
            w_y_nxt = w_yd ? w_y_inc[W-1:0] : w_y_dec[W-1:0];
          end
          w_wall_nxt = w_x_hi | w_x_lo | (w_y_top & ~w_y_floor);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_x     <= W'(X_INIT);
      r_y     <= W'(Y_INIT);
      r_x_du  <= 1'b1;
      r_y_du  <= 1'b0;
      r_cnt   <= '0;
      r_wall  <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_x_du  <= w_x_du_nxt;
      r_y_du  <= w_y_du_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wall  <= w_wall_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_x_du     = r_x_du;
  assign o_y_du     = r_y_du;
  assign o_wall_hit = r_wall;
  assign o_miss     = r_miss;
  assign o_moving   = (r_state == S_MOVE);
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: a cycle model feeds a scoreboard for the default instance,
// plus directed constant checks and a DIV=4 instance for divider timing.
module tb_ball_motion;
  logic       clk = 1'b0;
  logic       rst, en, lch, fx, fy;
  logic [2:0] sx, sy;
  logic [9:0] x, y;
  logic       xdu, ydu, wall, miss, mov;

  logic       d_rst, d_en, d_lch, d_fx, d_fy;
  logic [2:0] d_sx, d_sy;
  logic [9:0] d_x, d_y;
  logic       d_xdu, d_ydu, d_wall, d_miss, d_mov;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_launch(lch),
    .i_step_x(sx), .i_step_y(sy), .i_flip_x(fx), .i_flip_y(fy),
    .o_x(x), .o_y(y), .o_x_du(xdu), .o_y_du(ydu),
    .o_wall_hit(wall), .o_miss(miss), .o_moving(mov)
  );

  ball_motion #(.DIV(4)) u_div4 (
    .i_clk(clk), .i_reset(d_rst), .i_enable(d_en), .i_launch(d_lch),
    .i_step_x(d_sx), .i_step_y(d_sy), .i_flip_x(d_fx), .i_flip_y(d_fy),
    .o_x(d_x), .o_y(d_y), .o_x_du(d_xdu), .o_y_du(d_ydu),
    .o_wall_hit(d_wall), .o_miss(d_miss), .o_moving(d_mov)
  );

  typedef struct {int x; int y; int xdu; int ydu; int wall; int miss; int mov;} exp_t;
  exp_t sb[$];

  // reference model state: 0 idle, 1 move, 2 lost
  int m_st = 0, m_x = 316, m_y = 400, m_xdu = 1, m_ydu = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l,
                       input int stx, input int sty, input logic f_x, input logic f_y);
    exp_t ex;
    int nx, ny, w, m;
    rst = r; en = e; lch = l; sx = 3'(stx); sy = 3'(sty); fx = f_x; fy = f_y;
    w = 0; m = 0;
    if (r) begin
      m_st = 0; m_x = 316; m_y = 400; m_xdu = 1; m_ydu = 0;
    end else if (m_st == 0) begin
      if (l) m_st = 1;
    end else if (m_st == 2) begin
      if (l) begin m_st = 0; m_x = 316; m_y = 400; m_xdu = 1; m_ydu = 0; end
    end else begin
      if (f_x) m_xdu = 1 - m_xdu;
      if (f_y) m_ydu = 1 - m_ydu;
      if (e) begin
        nx = m_xdu ? m_x + stx : m_x - stx;
        ny = m_ydu ? m_y + sty : m_y - sty;
        if (nx > 631) begin m_x = 631; m_xdu = 0; w = 1; end
        else if (nx < 0) begin m_x = 0; m_xdu = 1; w = 1; end
        else m_x = nx;
        if (ny >= 471) begin m_y = 471; m = 1; m_st = 2; end
        else if (ny < 0) begin m_y = 0; m_ydu = 1; w = 1; end
        else m_y = ny;
      end
    end
    ex = '{m_x, m_y, m_xdu, m_ydu, w, m, (m_st == 1) ? 1 : 0};
    sb.push_back(ex);
    @(posedge clk); #1;
    ex = sb.pop_front();
    chk("x", int'(x), ex.x);
    chk("y", int'(y), ex.y);
    chk("x_du", int'(xdu), ex.xdu);
    chk("y_du", int'(ydu), ex.ydu);
    chk("wall_hit", int'(wall), ex.wall);
    chk("miss", int'(miss), ex.miss);
    chk("moving", int'(mov), ex.mov);
  endtask

  initial begin
    d_rst = 1; d_en = 0; d_lch = 0; d_fx = 0; d_fy = 0; d_sx = 0; d_sy = 0;

    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_x", int'(x), 316);
    chk("rst_y", int'(y), 400);
    chk("rst_mov", int'(mov), 0);

    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 2, 3, 0, 0);
      chk("serve_x", int'(x), 316 + 2 * i);
      chk("serve_y", int'(y), 400 - 3 * i);
    end
    chk("serve_mov", int'(mov), 1);

    // right wall
    repeat (44) drive(0, 1, 0, 7, 0, 0, 0);
    chk("pre_right_x", int'(x), 630);
    drive(0, 1, 0, 3, 0, 0, 0);
    chk("right_x", int'(x), 631);
    chk("right_du", int'(xdu), 0);
    chk("right_hit", int'(wall), 1);
    drive(0, 1, 0, 3, 0, 0, 0);
    chk("right_next_x", int'(x), 628);
    chk("right_hit_clr", int'(wall), 0);

    // top wall, with and without simultaneous flip
    repeat (55) drive(0, 1, 0, 0, 7, 0, 0);
    drive(0, 1, 0, 0, 4, 0, 0);
    chk("pre_top_y", int'(y), 2);
    drive(0, 1, 0, 0, 3, 0, 1);
    chk("flip_top_du", int'(ydu), 1);
    chk("flip_top_y", int'(y), 5);
    drive(0, 0, 0, 0, 3, 0, 1);
    chk("frozen_flip_du", int'(ydu), 0);
    chk("frozen_y", int'(y), 5);
    drive(0, 1, 0, 0, 3, 0, 0);
    drive(0, 1, 0, 0, 3, 0, 0);
    chk("top_y", int'(y), 0);
    chk("top_du", int'(ydu), 1);
    chk("top_hit", int'(wall), 1);

    // floor
    repeat (67) drive(0, 1, 0, 0, 7, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    chk("pre_floor_y", int'(y), 470);
    drive(0, 1, 0, 0, 2, 0, 0);
    chk("floor_y", int'(y), 471);
    chk("floor_miss", int'(miss), 1);
    chk("floor_mov", int'(mov), 0);
    drive(0, 1, 0, 5, 5, 1, 1);
    drive(0, 1, 0, 5, 5, 0, 0);
    chk("lost_hold_x", int'(x), 628);
    chk("lost_hold_y", int'(y), 471);
    chk("lost_miss_clr", int'(miss), 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("reserve_x", int'(x), 316);
    chk("reserve_y", int'(y), 400);
    chk("reserve_mov", int'(mov), 0);

    // reset mid-move beats launch
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (26) drive(0, 1, 0, 7, 0, 0, 0);
    drive(0, 1, 0, 2, 0, 0, 0);
    chk("mid_x", int'(x), 500);
    drive(1, 1, 1, 7, 7, 1, 1);
    chk("midrst_x", int'(x), 316);
    chk("midrst_y", int'(y), 400);
    chk("midrst_mov", int'(mov), 0);
    drive(0, 1, 0, 7, 7, 0, 0);
    chk("midrst_idle", int'(mov), 0);

    // DIV=4: enable pattern 1,1,0,0,1,1 with a flip during the frozen window
    @(posedge clk); #1;
    d_rst = 0; d_lch = 1; d_en = 1;
    @(posedge clk); #1;
    d_lch = 0; d_sx = 1;
    chk("d4_mov", int'(d_mov), 1);
    for (int i = 0; i < 6; i++) begin
      d_en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      d_fx = (i == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (i == 2) chk("d4_flip_du", int'(d_xdu), 0);
      chk("d4_x", int'(d_x), (i < 5) ? 316 : 315);
    end
    chk("d4_y", int'(d_y), 400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
